dbi_encoder_pipe: RTL

- Registered, multi-lane Data Bus Inversion encoder, the parametrised successor to the fixed 9-input DBI decision gate.
- Each LANE_W-bit lane gets its own invert decision in one of three modes: bypass, DBI-DC (minimise zeros) or DBI-AC (minimise transitions against the last word sent).
- Sits between the write-data path and the DQ serialiser.
- Valid/ready handshake on both sides; per-lane saturating inversion counters for link statistics.

---
 rtl/dbi_encoder_pipe.sv | 98 +++++++++
 1 files changed

// File: rtl/dbi_encoder_pipe.sv
// Registered multi-lane Data Bus Inversion encoder (bypass / DC / AC) with a
// valid/ready handshake on both sides and per-lane saturating inversion counters.
module dbi_encoder_pipe #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   in_data,
    input  logic [1:0]                in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic [LANES-1:0]          out_dbi,
    input  logic                      cnt_clr,
    output logic [LANES*CNT_W-1:0]    inv_count
);

    localparam int unsigned HALF = LANE_W / 2;

    logic [LANES*LANE_W-1:0] out_data_q, prev_data_q, enc_d;
    logic [LANES-1:0]        out_dbi_q, prev_dbi_q, inv_d;
    logic [LANES*CNT_W-1:0]  cnt_q;
    logic                    out_valid_q;
    logic                    accept;

    function automatic int unsigned popcnt(input logic [LANE_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < LANE_W; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_dbi   = out_dbi_q;
    assign inv_count = cnt_q;

    always_comb begin
        logic [LANE_W-1:0] lane;
        int unsigned       zeros;
        int unsigned       trans;
        lane  = '0;
        zeros = 0;
        trans = 0;
        enc_d = '0;
        inv_d = '0;
        for (int k = 0; k < LANES; k++) begin
            lane  = in_data[k*LANE_W +: LANE_W];
            zeros = LANE_W - popcnt(lane);
            trans = popcnt(lane ^ prev_data_q[k*LANE_W +: LANE_W]);
            case (in_mode)
                2'b01:   inv_d[k] = (zeros > HALF);
                // On a tie keep the previous DBI level so the DBI line itself does not toggle.
                2'b10:   inv_d[k] = (trans > HALF) || ((trans == HALF) && prev_dbi_q[k]);
                default: inv_d[k] = 1'b0;
            endcase
            enc_d[k*LANE_W +: LANE_W] = inv_d[k] ? ~lane : lane;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dbi_q   <= '0;
            prev_data_q <= '1;
            prev_dbi_q  <= '0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= enc_d;
                out_dbi_q   <= inv_d;
                prev_data_q <= enc_d;
                prev_dbi_q  <= inv_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            for (int k = 0; k < LANES; k++) begin
                if (cnt_clr) begin
                    cnt_q[k*CNT_W +: CNT_W] <= '0;
                end else if (accept && inv_d[k] &&
                             (cnt_q[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    cnt_q[k*CNT_W +: CNT_W] <= cnt_q[k*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end

endmodule
